// File: rtl/light_pkg.sv
// ============================================================================
// light_pkg : shared FSM state codes and PIO register map for the light servicer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package light_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT    = 3'd0;
    localparam state_t ST_IDLE    = 3'd1;
    localparam state_t ST_RD_CAP  = 3'd2;
    localparam state_t ST_CLR_CAP = 3'd3;
    localparam state_t ST_RD_DATA = 3'd4;
    localparam state_t ST_PUSH    = 3'd5;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    function automatic logic is_read_state(input state_t s);
        return (s == ST_RD_CAP) || (s == ST_RD_DATA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/light_sat_counter.sv
// ============================================================================
// light_sat_counter : W-bit up-counter that sticks at all-ones instead of wrapping
// Revision          : 1.0
// ============================================================================
`default_nettype none

module light_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/nios_qsys_light_irq_servicer.sv
// ============================================================================
// nios_qsys_light_irq_servicer : Avalon-MM master servicing the light PIO irq.
// Optional macro LIGHT_SVC_TIMESTAMP_EN adds ts_cnt and the event_ts port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nios_qsys_light_irq_servicer
    import light_pkg::*;
#(
    parameter logic MASK_VALUE   = 1'b1,
    parameter int   READ_LATENCY = 1,
    parameter int   CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             irq,
    output logic             event_valid,
    input  logic             event_ready,
    output logic             event_level,
    output logic [CNT_W-1:0] event_count,
    output logic [CNT_W-1:0] spurious_count
`ifdef LIGHT_SVC_TIMESTAMP_EN
    ,
    output logic [31:0]      event_ts
`endif
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_t     state_q, state_d;
    logic       run_q;
    logic [1:0] lat_q, lat_d;
    logic       level_q, level_d;
    logic       lat_last;
    logic       inc_event;
    logic       inc_spurious;
    logic       unused_readdata_bits;

    assign lat_last             = (lat_q == LAT_LAST);
    assign unused_readdata_bits = ^m_readdata[31:1];

    // run_q keeps the bus quiet during reset and delays the mask write to the
    // first full cycle after release, so INIT drives exactly one write cycle.
    always_comb begin
        state_d      = state_q;
        lat_d        = 2'd0;
        level_d      = level_q;
        inc_event    = 1'b0;
        inc_spurious = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (run_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (irq) state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                if (!lat_last) begin
                    lat_d = lat_q + 2'd1;
                end else if (m_readdata[0]) begin
                    state_d = ST_CLR_CAP;
                end else begin
                    inc_spurious = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_CLR_CAP: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (!lat_last) begin
                    lat_d = lat_q + 2'd1;
                end else begin
                    level_d = m_readdata[0];
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (event_ready) begin
                    inc_event = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            run_q   <= 1'b0;
            lat_q   <= 2'd0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            lat_q   <= lat_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = ADDR_DATA;
        m_writedata  = 32'd0;
        if (run_q) begin
            case (state_q)
                ST_INIT: begin
                    m_chipselect = 1'b1;
                    m_write_n    = 1'b0;
                    m_address    = ADDR_MASK;
                    m_writedata  = {31'd0, MASK_VALUE};
                end
                ST_CLR_CAP: begin
                    m_chipselect = 1'b1;
                    m_write_n    = 1'b0;
                    m_address    = ADDR_CAP;
                end
                default: begin
                    m_chipselect = is_read_state(state_q);
                    m_address    = (state_q == ST_RD_CAP) ? ADDR_CAP : ADDR_DATA;
                end
            endcase
        end
    end

    assign event_valid = (state_q == ST_PUSH);
    assign event_level = level_q;

    light_sat_counter #(.W(CNT_W)) u_event_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_event),
        .count   (event_count)
    );

    light_sat_counter #(.W(CNT_W)) u_spurious_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_spurious),
        .count   (spurious_count)
    );

`ifdef LIGHT_SVC_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] event_ts_q, event_ts_d;

    always_comb begin
        ts_cnt_d   = ts_cnt_q + 32'd1;
        event_ts_d = event_ts_q;
        if ((state_q == ST_IDLE) && irq) begin
            event_ts_d = ts_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q   <= 32'd0;
            event_ts_q <= 32'd0;
        end else begin
            ts_cnt_q   <= ts_cnt_d;
            event_ts_q <= event_ts_d;
        end
    end

    assign event_ts = event_ts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nios_qsys_light_irq_servicer.sv
// ============================================================================
// tb_nios_qsys_light_irq_servicer : directed + randomized bench with a PIO slave model
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nios_qsys_light_irq_servicer;

    localparam int CNT_W = 16;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       m_address;
    logic             m_chipselect;
    logic             m_write_n;
    logic [31:0]      m_writedata;
    logic [31:0]      m_readdata;
    logic             irq;
    logic             event_valid;
    logic             event_ready = 1'b0;
    logic             event_level;
    logic [CNT_W-1:0] event_count;
    logic [CNT_W-1:0] spurious_count;
`ifdef LIGHT_SVC_TIMESTAMP_EN
    logic [31:0]      event_ts;
    logic [31:0]      tb_ts;
`endif

    always #5 clk = ~clk;

    nios_qsys_light_irq_servicer #(
        .MASK_VALUE   (1'b1),
        .READ_LATENCY (1),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m_address      (m_address),
        .m_chipselect   (m_chipselect),
        .m_write_n      (m_write_n),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata),
        .irq            (irq),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_level    (event_level),
        .event_count    (event_count),
        .spurious_count (spurious_count)
`ifdef LIGHT_SVC_TIMESTAMP_EN
        ,
        .event_ts       (event_ts)
`endif
    );

    // Small saturating counter exercised directly to reach the all-ones boundary.
    logic       sat_inc = 1'b0;
    logic [2:0] sat_count;
    light_sat_counter #(.W(3)) u_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (sat_inc),
        .count   (sat_count)
    );

    // PIO slave model: falling-edge capture, register contents readable in the address cycle.
    logic in_port   = 1'b1;
    logic in_port_d = 1'b1;
    logic edge_cap  = 1'b0;
    logic irq_mask  = 1'b0;
    logic force_irq = 1'b0;

    always @(posedge clk) begin
        in_port_d <= in_port;
        if (m_chipselect && !m_write_n && m_address == 2'd2) irq_mask <= m_writedata[0];
        if (m_chipselect && !m_write_n && m_address == 2'd3) edge_cap <= 1'b0;
        if (in_port_d && !in_port) edge_cap <= 1'b1;
    end

    assign irq = (edge_cap & irq_mask) | force_irq;

    always_comb begin
        case (m_address)
            2'd0:    m_readdata = {31'd0, in_port};
            2'd2:    m_readdata = {31'd0, irq_mask};
            2'd3:    m_readdata = {31'd0, edge_cap};
            default: m_readdata = 32'd0;
        endcase
    end

    int bus_cycles  = 0;
    int mask_writes = 0;
    int cap_clears  = 0;
    always @(posedge clk) begin
        if (m_chipselect) begin
            bus_cycles <= bus_cycles + 1;
            if (!m_write_n && m_address == 2'd2 && m_writedata == 32'd1) mask_writes <= mask_writes + 1;
            if (!m_write_n && m_address == 2'd3 && m_writedata == 32'd0) cap_clears <= cap_clears + 1;
        end
    end

`ifdef LIGHT_SVC_TIMESTAMP_EN
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_ts <= 32'd0;
        else          tb_ts <= tb_ts + 32'd1;
    end
`endif

    int compared   = 0;
    int mismatched = 0;
    int exp_evt    = 0;
    int exp_spur   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse the sensor 1 -> 0, then leave it at 'after' once the edge is captured.
    task automatic sensor_fall(input logic after);
        in_port = 1'b1;
        tick();
        tick();
        in_port = 1'b0;
        tick();
        in_port = after;
    endtask

    task automatic expect_event(input logic lvl, input int stall);
        int n;
        event_ready = (stall == 0);
        n = 0;
        while (!event_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("event_valid_arrives", {31'd0, event_valid}, 32'd1);
        chk("event_level", {31'd0, event_level}, {31'd0, lvl});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("event_held_under_backpressure", {30'd0, event_valid, event_level}, {30'd0, 1'b1, lvl});
        end
        event_ready = 1'b1;
        @(posedge clk);
        exp_evt++;
        @(negedge clk);
        chk("event_valid_drops", {31'd0, event_valid}, 32'd0);
        chk("event_count", {16'd0, event_count}, exp_evt);
    endtask

    initial begin
        int n;
        int lat;
        logic seen;
        logic r;
        int stall;
        int gap;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_chipselect", {31'd0, m_chipselect}, 32'd0);
        chk("rst_write_n", {31'd0, m_write_n}, 32'd1);
        chk("rst_address", {30'd0, m_address}, 32'd0);
        chk("rst_writedata", m_writedata, 32'd0);
        chk("rst_outputs", {29'd0, event_valid, event_level, 1'b0}, 32'd0);
        chk("rst_counts", {event_count, spurious_count}, 32'd0);

        // Release: one mask write, then an idle bus
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("init_mask_writes", mask_writes, 32'd1);
        chk("init_bus_cycles", bus_cycles, 32'd1);
        chk("init_mask_reg", {31'd0, irq_mask}, 32'd1);
        chk("idle_bus", {30'd0, m_chipselect, m_write_n}, 32'd1);
        chk("idle_outputs", {15'd0, event_valid, event_count}, 32'd0);

        // First event, best-case latency from irq
        event_ready = 1'b1;
        in_port = 1'b0;
        n = 0;
        while (!irq && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("irq_rises", {31'd0, irq}, 32'd1);
        lat = 0;
        while (!event_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("irq_to_valid_latency", lat, 32'd4);
        expect_event(1'b0, 0);
        chk("capture_cleared", cap_clears, 32'd1);
        chk("irq_dropped", {31'd0, irq}, 32'd0);

        // Backpressure with two more edges during the stall: they coalesce into one event
        event_ready = 1'b0;
        sensor_fall(1'b0);
        n = 0;
        while (!event_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid", {31'd0, event_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1 || i == 5) in_port = 1'b1;
            if (i == 3 || i == 7) in_port = 1'b0;
            chk("stall_hold", {15'd0, event_valid, event_level, event_count}, {15'd0, 1'b1, 1'b0, 16'(exp_evt)});
        end
        chk("stall_irq_pending", {31'd0, irq}, 32'd1);
        event_ready = 1'b1;
        @(posedge clk);
        exp_evt++;
        @(negedge clk);
        chk("stall_release_count", {16'd0, event_count}, exp_evt);
        expect_event(1'b0, 0);
        repeat (6) @(negedge clk);
        chk("coalesced_no_extra", {15'd0, event_valid, event_count}, exp_evt);

        // Spurious irq with nothing captured
        tick();
        force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | event_valid;
        end
        exp_spur++;
        chk("spurious_count", {16'd0, spurious_count}, exp_spur);
        chk("spurious_no_event", {31'd0, seen}, 32'd0);
        chk("spurious_back_idle", {30'd0, m_chipselect, m_write_n}, 32'd1);
        chk("spurious_event_count", {16'd0, event_count}, exp_evt);

        // Randomized events: level is whatever the sensor holds when the data register is read
        for (int k = 0; k < 8; k++) begin
            r     = 1'($urandom_range(0, 1));
            stall = int'($urandom_range(0, 6));
            gap   = int'($urandom_range(0, 5));
            event_ready = (stall == 0);
            sensor_fall(r);
            expect_event(r, stall);
            repeat (gap) tick();
        end
        chk("random_spurious_stable", {16'd0, spurious_count}, exp_spur);

        // Reset during the capture-clear write
        event_ready = 1'b1;
        sensor_fall(1'b1);
        n = 0;
        @(negedge clk);
        while (!(m_chipselect && !m_write_n && m_address == 2'd3) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reached_clr_cap", {29'd0, m_chipselect, m_write_n, 1'b0}, 32'd4);
        reset_n = 1'b0;
        #1;
        chk("abort_bus", {29'd0, m_chipselect, m_write_n, m_address[0]}, 32'd2);
        chk("abort_outputs", {30'd0, event_valid, event_level}, 32'd0);
        chk("abort_counts", {event_count, spurious_count}, 32'd0);
        exp_evt  = 0;
        exp_spur = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reinit_mask_write", mask_writes, 32'd2);
        expect_event(1'b1, 0);

        // Saturation boundary on a narrow counter
        tick();
        sat_inc = 1'b1;
        repeat (5) tick();
        chk("sat_count_5", {29'd0, sat_count}, 32'd5);
        repeat (5) tick();
        chk("sat_count_holds", {29'd0, sat_count}, 32'd7);
        sat_inc = 1'b0;

`ifdef LIGHT_SVC_TIMESTAMP_EN
        begin
            logic [31:0] ts_first;
            logic [31:0] ts_second;
            event_ready = 1'b1;
            sensor_fall(1'b0);
            n = 0;
            while (!irq && n < 5) begin
                @(negedge clk);
                n++;
            end
            ts_first = tb_ts;
            expect_event(1'b0, 0);
            chk("event_ts_first", event_ts, ts_first);
            repeat (int'($urandom_range(1, 9))) tick();
            sensor_fall(1'b0);
            n = 0;
            while (!irq && n < 5) begin
                @(negedge clk);
                n++;
            end
            ts_second = tb_ts;
            expect_event(1'b0, 0);
            chk("event_ts_second", event_ts, ts_second);
            chk("event_ts_increasing", {31'd0, (ts_second > ts_first)}, 32'd1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
